// File: rtl/vc_dest_demux_if.sv
// Handshake bundle between a virtual-channel source FIFO, the destination demux and fifo_d0/fifo_d1.
// The slave modport is the demux; the master modport is the surrounding environment.
interface vc_dest_demux_if #(
   parameter int DATA_SIZE = 6,
   parameter int COUNT_W   = 8
);
   logic                 vc_empty;
   logic [DATA_SIZE-1:0] vc_data;
   logic                 vc_pop;
   logic                 fifo_pause_d0;
   logic                 fifo_pause_d1;
   logic                 push_d0;
   logic                 push_d1;
   logic [DATA_SIZE-1:0] data_d0;
   logic [DATA_SIZE-1:0] data_d1;
   logic                 stall;
   logic [COUNT_W-1:0]   cnt_d0;
   logic [COUNT_W-1:0]   cnt_d1;

   modport master (
      output vc_empty, vc_data, fifo_pause_d0, fifo_pause_d1,
      input  vc_pop, push_d0, push_d1, data_d0, data_d1, stall, cnt_d0, cnt_d1
   );

   modport slave (
      input  vc_empty, vc_data, fifo_pause_d0, fifo_pause_d1,
      output vc_pop, push_d0, push_d1, data_d0, data_d1, stall, cnt_d0, cnt_d1
   );
endinterface

// File: rtl/vc_dest_demux.sv
// Pops words from a VC FIFO and routes each to fifo_d0/fifo_d1 by its destination bit, holding a
// paused word in a one-entry skid register. Define DEMUX_CNT_EN to build the per-destination push counters.
module vc_dest_demux #(
   parameter int DATA_SIZE = 6,
   parameter int DEST_BIT  = 4,
   parameter int COUNT_W   = 8
) (
   input logic           clk,
   input logic           reset,
   vc_dest_demux_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t               state_q, state_d;
   logic [DATA_SIZE-1:0] hold_q;
   logic [DATA_SIZE-1:0] word;
   logic [DATA_SIZE-1:0] data_d0_q, data_d1_q;
   logic                 push_d0_q, push_d1_q;
   logic                 stall_q, stall_d;
   logic                 sel, pause_sel, route, pop;

   // Decision logic: in FETCH the word is the fresh FIFO read data, in HOLD it is the skid copy.
   always_comb begin
      word      = (state_q == HOLD) ? hold_q : bus.vc_data;
      sel       = word[DEST_BIT];
      pause_sel = sel ? bus.fifo_pause_d1 : bus.fifo_pause_d0;
      state_d   = state_q;
      stall_d   = stall_q;
      pop       = 1'b0;
      route     = 1'b0;
      case (state_q)
         IDLE: begin
            pop = !bus.vc_empty;
            if (pop) state_d = FETCH;
         end
         FETCH, HOLD: begin
            if (pause_sel) begin
               state_d = HOLD;
               stall_d = 1'b1;
            end else begin
               route   = 1'b1;
               stall_d = 1'b0;
               pop     = !bus.vc_empty;
               state_d = pop ? FETCH : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) pop = 1'b0;
   end

   // hold_q always captures the read data in FETCH so a paused word survives into HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         push_d0_q <= 1'b0;
         push_d1_q <= 1'b0;
         data_d0_q <= '0;
         data_d1_q <= '0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (state_q == FETCH) hold_q <= bus.vc_data;
         push_d0_q <= route & ~sel;
         push_d1_q <= route & sel;
         if (route & ~sel) data_d0_q <= word;
         if (route & sel)  data_d1_q <= word;
         stall_q   <= stall_d;
      end
   end

   assign bus.vc_pop  = pop;
   assign bus.push_d0 = push_d0_q;
   assign bus.push_d1 = push_d1_q;
   assign bus.data_d0 = data_d0_q;
   assign bus.data_d1 = data_d1_q;
   assign bus.stall   = stall_q;

`ifdef DEMUX_CNT_EN
   logic [COUNT_W-1:0] cnt_d0_q, cnt_d1_q;

   // Counters advance on the same edge that raises the push strobe, wrapping modulo 2**COUNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_d0_q <= '0;
         cnt_d1_q <= '0;
      end else begin
         if (route & ~sel) cnt_d0_q <= cnt_d0_q + COUNT_W'(1);
         if (route & sel)  cnt_d1_q <= cnt_d1_q + COUNT_W'(1);
      end
   end

   assign bus.cnt_d0 = cnt_d0_q;
   assign bus.cnt_d1 = cnt_d1_q;
`else
   assign bus.cnt_d0 = '0;
   assign bus.cnt_d1 = '0;
`endif

endmodule

// File: tb/tb_vc_dest_demux.sv
// Scoreboard bench for vc_dest_demux: a source FIFO model feeds words, every push is checked in order
// against the expected-word queue along with destination, data and push counters.
module tb_vc_dest_demux;
   localparam int DATA_SIZE = 6;
   localparam int DEST_BIT  = 4;
   localparam int COUNT_W   = 8;
`ifdef DEMUX_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic                 dest;
      logic [DATA_SIZE-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   vc_dest_demux_if #(.DATA_SIZE(DATA_SIZE), .COUNT_W(COUNT_W)) bus ();

   vc_dest_demux #(.DATA_SIZE(DATA_SIZE), .DEST_BIT(DEST_BIT), .COUNT_W(COUNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_SIZE-1:0] src_q[$];
   exp_t                 exp_q[$];
   logic [COUNT_W-1:0]   exp_cnt0, exp_cnt1;
   logic                 pop_seen, last_p0, last_p1, last_stall;
   int                   compared   = 0;
   int                   mismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic loadWord(input logic [DATA_SIZE-1:0] w);
      exp_t e;
      e.dest = w[DEST_BIT];
      e.data = w;
      src_q.push_back(w);
      exp_q.push_back(e);
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic applyStimulus();
      exp_t e;
      bus.vc_empty = (src_q.size() == 0);
      #1;
      last_p0    = bus.push_d0;
      last_p1    = bus.push_d1;
      last_stall = bus.stall;
      checkOutput("push_exclusive", {31'd0, last_p0 & last_p1}, 32'd0);
      if (last_p0 | last_p1) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_push", {30'd0, last_p1, last_p0}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("push_dest", {31'd0, last_p1}, {31'd0, e.dest});
            checkOutput("push_data", e.dest ? bus.data_d1 : bus.data_d0, e.data);
            if (e.dest) exp_cnt1 = exp_cnt1 + 8'd1;
            else        exp_cnt0 = exp_cnt0 + 8'd1;
            checkOutput("cnt_d0", bus.cnt_d0, CNT_EN ? exp_cnt0 : 8'd0);
            checkOutput("cnt_d1", bus.cnt_d1, CNT_EN ? exp_cnt1 : 8'd0);
         end
      end
      pop_seen = bus.vc_pop;
      @(posedge clk);
      @(negedge clk);
      if (pop_seen) begin
         if (src_q.size() == 0) checkOutput("pop_when_empty", {31'd0, pop_seen}, 32'd0);
         else                   bus.vc_data = src_q.pop_front();
      end
   endtask

   task automatic doReset();
      reset             = 1'b1;
      bus.fifo_pause_d0 = 1'b0;
      bus.fifo_pause_d1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      src_q.delete();
      exp_q.delete();
      exp_cnt0 = '0;
      exp_cnt1 = '0;
      pop_seen = 1'b0;
   endtask

   task automatic drain(input int limit, input bit rnd_pause);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         if (rnd_pause) begin
            bus.fifo_pause_d0 = ($urandom_range(0, 3) == 0);
            bus.fifo_pause_d1 = ($urandom_range(0, 3) == 0);
         end
         applyStimulus();
         n++;
      end
      bus.fifo_pause_d0 = 1'b0;
      bus.fifo_pause_d1 = 1'b0;
      checkOutput("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      reset             = 1'b1;
      bus.vc_empty      = 1'b0;
      bus.vc_data       = '0;
      bus.fifo_pause_d0 = 1'b0;
      bus.fifo_pause_d1 = 1'b0;
      exp_cnt0          = '0;
      exp_cnt1          = '0;
      pop_seen          = 1'b0;

      // Reset with a non-empty source: nothing may pop or push.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_vc_pop", {31'd0, bus.vc_pop}, 32'd0);
      checkOutput("rst_push", {30'd0, bus.push_d1, bus.push_d0}, 32'd0);
      checkOutput("rst_data_d0", bus.data_d0, 32'd0);
      checkOutput("rst_data_d1", bus.data_d1, 32'd0);
      checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("rst_cnt_d0", bus.cnt_d0, 32'd0);
      checkOutput("rst_cnt_d1", bus.cnt_d1, 32'd0);
      bus.vc_empty = 1'b1;
      reset        = 1'b0;
      @(negedge clk);

      // Single d0 word: pop at N, push at N+2.
      loadWord(6'h05);
      applyStimulus();
      checkOutput("t2_pop_N", {31'd0, pop_seen}, 32'd1);
      applyStimulus();
      checkOutput("t2_nopush_N1", {31'd0, last_p0 | last_p1}, 32'd0);
      applyStimulus();
      checkOutput("t2_push_d0_N2", {31'd0, last_p0}, 32'd1);
      checkOutput("t2_push_d1_N2", {31'd0, last_p1}, 32'd0);
      checkOutput("t2_cnt_d0", bus.cnt_d0, CNT_EN ? 32'd1 : 32'd0);

      // Back-to-back stream d1, d0, d1.
      doReset();
      loadWord(6'h11); loadWord(6'h02); loadWord(6'h13);
      applyStimulus(); applyStimulus();
      applyStimulus(); checkOutput("t3_push0_d1", {31'd0, last_p1}, 32'd1);
      applyStimulus(); checkOutput("t3_push1_d0", {31'd0, last_p0}, 32'd1);
      applyStimulus(); checkOutput("t3_push2_d1", {31'd0, last_p1}, 32'd1);
      checkOutput("t3_cnt_d0", bus.cnt_d0, CNT_EN ? 32'd1 : 32'd0);
      checkOutput("t3_cnt_d1", bus.cnt_d1, CNT_EN ? 32'd2 : 32'd0);

      // Paused d1 word is held; a second word waits behind it.
      bus.fifo_pause_d1 = 1'b1;
      loadWord(6'h12); loadWord(6'h05);
      applyStimulus();
      applyStimulus();
      checkOutput("t4_pop_decide", {31'd0, pop_seen}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus();
         checkOutput("t4_stall", {31'd0, last_stall}, 32'd1);
         checkOutput("t4_pop_held", {31'd0, pop_seen}, 32'd0);
         checkOutput("t4_no_push", {31'd0, last_p0 | last_p1}, 32'd0);
      end
      bus.fifo_pause_d1 = 1'b0;
      applyStimulus();
      checkOutput("t4_b2b_pop", {31'd0, pop_seen}, 32'd1);
      applyStimulus();
      checkOutput("t4_push_d1", {31'd0, last_p1}, 32'd1);
      checkOutput("t4_stall_clr", {31'd0, last_stall}, 32'd0);
      drain(10, 1'b0);

      // Pause on the non-selected destination is ignored.
      bus.fifo_pause_d0 = 1'b1;
      for (int k = 0; k < 4; k++) loadWord(6'(6'h10 + k));
      applyStimulus(); applyStimulus();
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkOutput("t5_push_d1", {31'd0, last_p1}, 32'd1);
         checkOutput("t5_no_stall", {31'd0, last_stall}, 32'd0);
      end
      bus.fifo_pause_d0 = 1'b0;

      // Reset while a word sits in HOLD discards it.
      doReset();
      bus.fifo_pause_d0 = 1'b1;
      loadWord(6'h07);
      applyStimulus(); applyStimulus(); applyStimulus();
      checkOutput("t6_stall_hold", {31'd0, last_stall}, 32'd1);
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkOutput("t6_no_push", {31'd0, last_p0 | last_p1}, 32'd0);
         checkOutput("t6_stall_clr", {31'd0, last_stall}, 32'd0);
      end
      loadWord(6'h03);
      drain(10, 1'b0);
      checkOutput("t6_cnt_d0", bus.cnt_d0, CNT_EN ? 32'd1 : 32'd0);

      // 256 d0 pushes wrap the counter to zero.
      doReset();
      for (int k = 0; k < 256; k++) loadWord(6'($urandom) & 6'h2F);
      drain(400, 1'b0);
      checkOutput("cnt_d0_wrap", bus.cnt_d0, 32'd0);

      // Mixed destinations with random pauses.
      doReset();
      for (int k = 0; k < 80; k++) loadWord(6'($urandom));
      drain(2000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
